// File: rtl/display_capture.sv
// -----------------------------------------------------------------------------
// display_capture
//
// Receive-side monitor for a row-scanned LED panel. Samples the panel pins,
// rebuilds every latched row as a parallel word with its row address, measures
// how long output enable was held low after each latch, and flags protocol
// violations (wrong bit count per row, shifting/latching while the panel is lit).
//
// Configuration macro:
//   DISPLAY_CAPTURE_SYNC_EN - when defined, every pin passes through a 2-flop
//                             synchronizer before the sample register
//                             (3-cycle action latency, asynchronous source).
//                             When undefined, a single sample register is used
//                             (1-cycle latency, source must be in the clk domain).
//
// Ports:
//   clk, rst        system clock (rising edge), synchronous active-high reset
//   pin_clk         panel shift clock, data taken on its rising edge
//   pin_lat         latch, active low (row captured on its falling edge)
//   pin_oe          output enable, active low
//   pin_row         row address, captured with the latch
//   pin_data        serial data, lanes bits per shift edge
//   row_valid       one-cycle strobe, row_addr/row_data updated
//   row_addr        row address latched with the row
//   row_data        bits [c*lanes +: lanes] hold the data of the c-th shift edge
//   on_valid        one-cycle strobe, on_time updated
//   on_time         clk cycles pin_oe was low, saturating
//   frame_done      one-cycle strobe with on_valid when row_addr == rows-1
//   err_len         sticky: a latch saw a bit count other than columns
//   err_oe          sticky: shift edge or latch fall while the panel was lit
// -----------------------------------------------------------------------------
module display_capture #(
    parameter int rows        = 8,
    parameter int columns     = 32,
    parameter int lanes       = 1,
    parameter int count_width = 16,
    localparam int ra_w       = (rows > 1) ? $clog2(rows) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pin_clk,
    input  logic                     pin_lat,
    input  logic                     pin_oe,
    input  logic [ra_w-1:0]          pin_row,
    input  logic [lanes-1:0]         pin_data,
    output logic                     row_valid,
    output logic [ra_w-1:0]          row_addr,
    output logic [columns*lanes-1:0] row_data,
    output logic                     on_valid,
    output logic [count_width-1:0]   on_time,
    output logic                     frame_done,
    output logic                     err_len,
    output logic                     err_oe
);

    localparam int bc_w = $clog2(columns + 1);
    localparam int dw   = columns * lanes;
    // All pins travel as one bus so data/row stay aligned with clk/lat.
    localparam int pw   = 3 + ra_w + lanes;
    // Idle pin levels: shift clock low, latch and output enable high.
    localparam logic [pw-1:0] pin_idle = {1'b0, 1'b1, 1'b1, {ra_w{1'b0}}, {lanes{1'b0}}};

    // Error-classification FSM
    localparam logic [1:0] S_SHIFT   = 2'd0;
    localparam logic [1:0] S_LATCH   = 2'd1;
    localparam logic [1:0] S_ARMED   = 2'd2;
    localparam logic [1:0] S_DISPLAY = 2'd3;

    logic [pw-1:0] pins_raw;
    logic [pw-1:0] stage_in;
    assign pins_raw = {pin_clk, pin_lat, pin_oe, pin_row, pin_data};

`ifdef DISPLAY_CAPTURE_SYNC_EN
    logic [pw-1:0] sync1_q, sync1_d;
    logic [pw-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = pins_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= pin_idle;
            sync2_q <= pin_idle;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign stage_in = sync2_q;
`else
    assign stage_in = pins_raw;
`endif

    // Sample register and previous levels of clk/lat/oe for edge detection
    logic [pw-1:0] samp_q, samp_d;
    logic [2:0]    prev_q, prev_d;

    logic                 s_clk, s_lat, s_oe;
    logic [ra_w-1:0]      s_row;
    logic [lanes-1:0]     s_data;
    logic                 shift_edge, lat_fall, lat_rise, oe_fall, oe_rise;

    assign s_clk  = samp_q[pw-1];
    assign s_lat  = samp_q[pw-2];
    assign s_oe   = samp_q[pw-3];
    assign s_row  = samp_q[lanes +: ra_w];
    assign s_data = samp_q[lanes-1:0];

    assign shift_edge =  s_clk & ~prev_q[2];
    assign lat_fall   = ~s_lat &  prev_q[1];
    assign lat_rise   =  s_lat & ~prev_q[1];
    assign oe_fall    = ~s_oe  &  prev_q[0];
    assign oe_rise    =  s_oe  & ~prev_q[0];

    // Row assembly and output state
    logic [dw-1:0]          shadow_q, shadow_d;
    logic [bc_w-1:0]        bit_cnt_q, bit_cnt_d;
    logic                   row_valid_q, row_valid_d;
    logic [ra_w-1:0]        row_addr_q, row_addr_d;
    logic [dw-1:0]          row_data_q, row_data_d;
    logic [count_width-1:0] cnt_q, cnt_d;
    logic                   on_valid_q, on_valid_d;
    logic [count_width-1:0] on_time_q, on_time_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_len_q, err_len_d;
    logic                   err_oe_q, err_oe_d;
    logic [1:0]             state_q, state_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        samp_d       = stage_in;
        prev_d       = {s_clk, s_lat, s_oe};
        shadow_d     = shadow_q;
        bit_cnt_d    = bit_cnt_q;
        row_valid_d  = 1'b0;
        row_addr_d   = row_addr_q;
        row_data_d   = row_data_q;
        cnt_d        = cnt_q;
        on_valid_d   = 1'b0;
        on_time_d    = on_time_q;
        frame_done_d = 1'b0;
        err_len_d    = err_len_q;
        err_oe_d     = err_oe_q;
        state_d      = state_q;

        // Shift runs before latch so a coincident bit lands in the latched word.
        if (shift_edge) begin
            if (bit_cnt_q < bc_w'(columns)) begin
                for (int c = 0; c < columns; c++) begin
                    if (bit_cnt_q == bc_w'(c)) begin
                        shadow_d[c*lanes +: lanes] = s_data;
                    end
                end
                bit_cnt_d = bit_cnt_q + bc_w'(1);
            end else begin
                err_len_d = 1'b1;
            end
        end

        if (lat_fall) begin
            row_data_d  = shadow_d;
            row_addr_d  = s_row;
            row_valid_d = 1'b1;
            if (bit_cnt_d != bc_w'(columns)) begin
                err_len_d = 1'b1;
            end
            shadow_d  = '0;
            bit_cnt_d = '0;
        end

        // On-time: the fall counts as the first low cycle, the rise reports.
        if (oe_fall) begin
            cnt_d = count_width'(1);
        end else if (!s_oe && cnt_q != {count_width{1'b1}}) begin
            cnt_d = cnt_q + count_width'(1);
        end

        if (oe_rise) begin
            on_time_d    = cnt_q;
            on_valid_d   = 1'b1;
            frame_done_d = (row_addr_q == ra_w'(rows - 1));
        end

        case (state_q)
            S_SHIFT: begin
                if (lat_fall) state_d = S_LATCH;
            end
            S_LATCH: begin
                if (lat_rise) state_d = S_ARMED;
            end
            S_ARMED: begin
                // Skipping the display phase is legal
                if (oe_fall)         state_d = S_DISPLAY;
                else if (shift_edge) state_d = S_SHIFT;
            end
            S_DISPLAY: begin
                if (shift_edge || lat_fall) err_oe_d = 1'b1;
                if (oe_rise) state_d = S_SHIFT;
            end
            default: state_d = S_SHIFT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the shadow row register is cleared on reset as well, so a
        // partial row can never leak into the first word after reset.
        if (rst) begin
            samp_q       <= pin_idle;
            prev_q       <= 3'b011;
            shadow_q     <= '0;
            bit_cnt_q    <= '0;
            row_valid_q  <= 1'b0;
            row_addr_q   <= '0;
            row_data_q   <= '0;
            cnt_q        <= '0;
            on_valid_q   <= 1'b0;
            on_time_q    <= '0;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_oe_q     <= 1'b0;
            state_q      <= S_SHIFT;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of the others.
            samp_q       <= samp_d;
            prev_q       <= prev_d;
            shadow_q     <= shadow_d;
            bit_cnt_q    <= bit_cnt_d;
            row_valid_q  <= row_valid_d;
            row_addr_q   <= row_addr_d;
            row_data_q   <= row_data_d;
            cnt_q        <= cnt_d;
            on_valid_q   <= on_valid_d;
            on_time_q    <= on_time_d;
            frame_done_q <= frame_done_d;
            err_len_q    <= err_len_d;
            err_oe_q     <= err_oe_d;
            state_q      <= state_d;
        end
    end

    assign row_valid  = row_valid_q;
    assign row_addr   = row_addr_q;
    assign row_data   = row_data_q;
    assign on_valid   = on_valid_q;
    assign on_time    = on_time_q;
    assign frame_done = frame_done_q;
    assign err_len    = err_len_q;
    assign err_oe     = err_oe_q;

endmodule

// File: tb/tb_display_capture.sv
// -----------------------------------------------------------------------------
// tb_display_capture
//
// Directed bench for display_capture with default parameters (8 rows,
// 32 columns, 1 lane, 16-bit on-time). Pins are driven on the falling clk edge
// and outputs observed on the falling edge. Each pin level is held at least two
// cycles so the same stimulus is valid with or without DISPLAY_CAPTURE_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_display_capture;

`ifdef DISPLAY_CAPTURE_SYNC_EN
    localparam int lat_cycles = 3;
`else
    localparam int lat_cycles = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pin_clk, pin_lat, pin_oe;
    logic [2:0]  pin_row;
    logic [0:0]  pin_data;
    logic        row_valid, on_valid, frame_done, err_len, err_oe;
    logic [2:0]  row_addr;
    logic [31:0] row_data;
    logic [15:0] on_time;

    int pass_cnt  = 0;
    int total_cnt = 0;

    display_capture dut (
        .clk        (clk),
        .rst        (rst),
        .pin_clk    (pin_clk),
        .pin_lat    (pin_lat),
        .pin_oe     (pin_oe),
        .pin_row    (pin_row),
        .pin_data   (pin_data),
        .row_valid  (row_valid),
        .row_addr   (row_addr),
        .row_data   (row_data),
        .on_valid   (on_valid),
        .on_time    (on_time),
        .frame_done (frame_done),
        .err_len    (err_len),
        .err_oe     (err_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses and captures values seen with them
    int          rv_cnt = 0, rv_cyc = 0;
    logic [31:0] rv_data = '0;
    logic [2:0]  rv_addr = '0;
    int          ov_cnt = 0, ov_cyc = 0, fd_cnt = 0;
    logic [15:0] ov_time = '0;
    logic        ov_frame = 1'b0;

    always @(negedge clk) begin
        if (row_valid === 1'b1) begin
            rv_cnt  = rv_cnt + 1;
            rv_cyc  = cyc;
            rv_data = row_data;
            rv_addr = row_addr;
        end
        if (on_valid === 1'b1) begin
            ov_cnt   = ov_cnt + 1;
            ov_cyc   = cyc;
            ov_time  = on_time;
            ov_frame = frame_done;
        end
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic shift_bit(input logic b);
        pin_data = b;
        repeat (2) @(negedge clk);
        pin_clk = 1'b1;
        repeat (2) @(negedge clk);
        pin_clk = 1'b0;
    endtask

    task automatic shift_word(input logic [31:0] w, input int n);
        for (int c = 0; c < n; c++) shift_bit(w[c]);
    endtask

    task automatic do_latch(input logic [2:0] r, output int d);
        pin_row = r;
        repeat (2) @(negedge clk);
        pin_lat = 1'b0;
        d = cyc;
        repeat (2) @(negedge clk);
        pin_lat = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic oe_pulse(input int n, output int d);
        pin_oe = 1'b0;
        repeat (n) @(negedge clk);
        pin_oe = 1'b1;
        d = cyc;
        repeat (8) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        total_cnt++;
        if ({row_valid, on_valid, frame_done, err_len, err_oe} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {row_valid, on_valid, frame_done, err_len, err_oe});
        else pass_cnt++;
        total_cnt++;
        if (row_data !== 32'h0) $display("FAIL reset_row_data: got %h want 00000000", row_data);
        else pass_cnt++;
        total_cnt++;
        if ({row_addr, on_time} !== 19'h0) $display("FAIL reset_addr_time: got %h/%h want 0/0", row_addr, on_time);
        else pass_cnt++;
    endtask

    task automatic test_nominal;
        int b, d;
        b = rv_cnt;
        shift_word(32'hA5A50F0F, 32);
        do_latch(3'd3, d);
        total_cnt++;
        if (rv_cnt - b !== 1) $display("FAIL nominal_strobes: got %0d want 1", rv_cnt - b);
        else pass_cnt++;
        total_cnt++;
        if (rv_data !== 32'hA5A50F0F) $display("FAIL nominal_data: got %h want a5a50f0f", rv_data);
        else pass_cnt++;
        total_cnt++;
        if (rv_addr !== 3'd3) $display("FAIL nominal_addr: got %0d want 3", rv_addr);
        else pass_cnt++;
        total_cnt++;
        if (err_len !== 1'b0) $display("FAIL nominal_err_len: got %b want 0", err_len);
        else pass_cnt++;
        total_cnt++;
        if (rv_cyc !== d + 1 + lat_cycles)
            $display("FAIL row_latency: got %0d want %0d", rv_cyc - d - 1, lat_cycles);
        else pass_cnt++;
    endtask

    task automatic test_on_time_frame;
        int b, fb, d;
        shift_word(32'h12345678, 32);
        do_latch(3'd7, d);
        b  = ov_cnt;
        fb = fd_cnt;
        oe_pulse(8, d);
        total_cnt++;
        if (ov_cnt - b !== 1) $display("FAIL on_strobes: got %0d want 1", ov_cnt - b);
        else pass_cnt++;
        total_cnt++;
        if (ov_time !== 16'd8) $display("FAIL on_time_8: got %0d want 8", ov_time);
        else pass_cnt++;
        total_cnt++;
        if (ov_frame !== 1'b1 || fd_cnt - fb !== 1)
            $display("FAIL frame_row7: got %b/%0d want 1/1", ov_frame, fd_cnt - fb);
        else pass_cnt++;
        total_cnt++;
        if (ov_cyc !== d + 1 + lat_cycles)
            $display("FAIL on_latency: got %0d want %0d", ov_cyc - d - 1, lat_cycles);
        else pass_cnt++;

        shift_word(32'h0, 32);
        do_latch(3'd2, d);
        fb = fd_cnt;
        oe_pulse(5, d);
        total_cnt++;
        if (ov_time !== 16'd5) $display("FAIL on_time_5: got %0d want 5", ov_time);
        else pass_cnt++;
        total_cnt++;
        if (ov_frame !== 1'b0 || fd_cnt !== fb)
            $display("FAIL frame_row2: got %b/%0d want 0/0", ov_frame, fd_cnt - fb);
        else pass_cnt++;
        total_cnt++;
        if ({err_len, err_oe} !== 2'b00) $display("FAIL clean_errors: got %b want 00", {err_len, err_oe});
        else pass_cnt++;
    endtask

    task automatic test_short_row;
        int d;
        shift_word(32'hFFFFFFFF, 31);
        do_latch(3'd1, d);
        total_cnt++;
        if (rv_data !== 32'h7FFFFFFF) $display("FAIL short_data: got %h want 7fffffff", rv_data);
        else pass_cnt++;
        total_cnt++;
        if (err_len !== 1'b1) $display("FAIL short_err_len: got %b want 1", err_len);
        else pass_cnt++;
        shift_word(32'hCAFEBABE, 32);
        do_latch(3'd5, d);
        total_cnt++;
        if (rv_data !== 32'hCAFEBABE || rv_addr !== 3'd5)
            $display("FAIL after_short_row: got %h@%0d want cafebabe@5", rv_data, rv_addr);
        else pass_cnt++;
        total_cnt++;
        if (err_len !== 1'b1) $display("FAIL err_len_sticky: got %b want 1", err_len);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_row;
        int d;
        shift_word(32'hFFFFFFFF, 10);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({row_valid, on_valid, frame_done, err_len, err_oe} !== 5'b0)
            $display("FAIL midrst_flags: got %b want 00000", {row_valid, on_valid, frame_done, err_len, err_oe});
        else pass_cnt++;
        total_cnt++;
        if (row_data !== 32'h0 || row_addr !== 3'd0 || on_time !== 16'd0)
            $display("FAIL midrst_values: got %h/%0d/%0d want 0/0/0", row_data, row_addr, on_time);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        shift_word(32'hFFFFFFFF, 32);
        do_latch(3'd6, d);
        total_cnt++;
        if (rv_data !== 32'hFFFFFFFF || rv_addr !== 3'd6)
            $display("FAIL midrst_row: got %h@%0d want ffffffff@6", rv_data, rv_addr);
        else pass_cnt++;
        total_cnt++;
        if (err_len !== 1'b0) $display("FAIL midrst_err_len: got %b want 0", err_len);
        else pass_cnt++;
    endtask

    task automatic test_oe_violation;
        int d;
        shift_word(32'h0, 32);
        do_latch(3'd4, d);
        total_cnt++;
        if (err_oe !== 1'b0) $display("FAIL pre_err_oe: got %b want 0", err_oe);
        else pass_cnt++;
        pin_oe = 1'b0;
        repeat (2) @(negedge clk);
        shift_bit(1'b1);
        repeat (2) @(negedge clk);
        pin_oe = 1'b1;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (err_oe !== 1'b1) $display("FAIL err_oe_set: got %b want 1", err_oe);
        else pass_cnt++;
        total_cnt++;
        if (ov_time !== 16'd8 || ov_frame !== 1'b0)
            $display("FAIL violation_on_time: got %0d/%b want 8/0", ov_time, ov_frame);
        else pass_cnt++;
        shift_word(32'h0, 31);
        do_latch(3'd0, d);
        total_cnt++;
        if (rv_data !== 32'h00000001) $display("FAIL violation_bit_kept: got %h want 00000001", rv_data);
        else pass_cnt++;
        total_cnt++;
        if ({err_len, err_oe} !== 2'b01) $display("FAIL violation_flags: got %b want 01", {err_len, err_oe});
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        int b, d;
        b = ov_cnt;
        oe_pulse(70000, d);
        total_cnt++;
        if (ov_cnt - b !== 1) $display("FAIL sat_strobes: got %0d want 1", ov_cnt - b);
        else pass_cnt++;
        total_cnt++;
        if (ov_time !== 16'hFFFF) $display("FAIL sat_on_time: got %0d want 65535", ov_time);
        else pass_cnt++;
        total_cnt++;
        if (ov_cyc !== d + 1 + lat_cycles)
            $display("FAIL sat_latency: got %0d want %0d", ov_cyc - d - 1, lat_cycles);
        else pass_cnt++;
    endtask

    initial begin
        rst      = 1'b1;
        pin_clk  = 1'b0;
        pin_lat  = 1'b1;
        pin_oe   = 1'b1;
        pin_row  = '0;
        pin_data = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_nominal;
        test_on_time_frame;
        test_short_row;
        test_reset_mid_row;
        test_oe_violation;
        test_saturation;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/display_capture.md
# display_capture

Receive-side counterpart of the row-scanned LED panel driver. It samples the panel pins (shift clock, active-low latch, active-low output enable, row address, serial data) and rebuilds each latched row as a parallel word with its row address and measured on-time. It also flags protocol violations. It is used as a loop-back monitor in the bench and on hardware, and as the input stage of a chained panel.

## Interface
Parameters:
- rows, 8: number of addressable rows; ra_w = $clog2(rows)
- columns, 32: bits shifted per row
- lanes, 1: parallel data lines per shift clock
- count_width, 16: on-time counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pin_clk  in  1  panel shift clock; data taken on rising edge
- pin_lat  in  1  latch, active low
- pin_oe  in  1  output enable, active low
- pin_row  in  ra_w  row address
- pin_data  in  lanes  serial data
- row_valid  out  1  one-cycle strobe; row_addr and row_data are updated
- row_addr  out  ra_w  address latched with the row
- row_data  out  columns*lanes  bits [c*lanes +: lanes] = data from the c-th shift edge (c from 0)
- on_valid  out  1  one-cycle strobe; on_time is updated
- on_time  out  count_width  clk cycles pin_oe was low, saturating
- frame_done  out  1  one-cycle strobe on on_valid when row_addr == rows-1
- err_len  out  1  sticky: a latch occurred with bit count != columns
- err_oe  out  1  sticky: a shift edge or latch fall occurred while pin_oe was low

## Operation
- Input stage: all pins pass through sample registers; with the sync feature, through 2-flop synchronizers first. Reset values of the sample registers are the idle levels (clk 0, lat 1, oe 1), so no edge is seen after reset.
- Edges are detected on sampled values. pin_data and pin_row are sampled in the same stage as pin_clk and pin_lat.
- Shift, on every pin_clk rise:
  - if bit_cnt < columns: write the lanes bits to shadow[bit_cnt*lanes +: lanes] and increment bit_cnt;
  - otherwise the bits are discarded and err_len is set.
- Latch, on pin_lat fall:
  - row_data <= shadow, row_addr <= pin_row, row_valid = 1;
  - err_len is set if bit_cnt != columns;
  - shadow and bit_cnt are cleared.
- If a shift edge and a latch fall occur in the same cycle, the bit is written first and the word includes it.
- On-time, on pin_oe fall: cnt <= 1. While low: cnt increments, saturating at 2^count_width-1. On pin_oe rise: on_time <= cnt and on_valid = 1; frame_done = 1 if row_addr == rows-1.
- FSM (error classification only; shift and latch actions run in every state):
  - S_SHIFT: on lat fall, go to S_LATCH.
  - S_LATCH: on lat rise, go to S_ARMED.
  - S_ARMED: on oe fall, go to S_DISPLAY; on shift edge, go to S_SHIFT (display skipped, not an error).
  - S_DISPLAY: on oe rise, go to S_SHIFT. A shift edge or lat fall here sets err_oe.
- Reset mid-operation: the partial row is discarded; every output, flag, counter and shadow goes to 0; FSM goes to S_SHIFT.

## Timing
- E0 is the first clk edge that samples a changed pin level.
- Without sync: actions are registered at E1 (row_valid, on_valid, frame_done, err flags are high in the cycle after E1).
- With sync: actions are registered at E3.
- Each strobe lasts exactly one cycle.
- Input rate: each pin level must persist ≥1 clk cycle without sync, ≥2 with sync. pin_data and pin_row must be stable from one cycle before through the shift or latch edge.
- on_time equals the number of clk cycles pin_oe was sampled low. Both edges take the same path, so the pipeline delay cancels.
- Throughput: one row per latch. There is no back-pressure; a consumer must take row_data on row_valid.

## Configuration
- DISPLAY_CAPTURE_SYNC_EN defined: 2-flop synchronizers on all pins, 3-cycle action latency, suitable for an asynchronous panel source.
- Not defined: single sample register, 1-cycle latency. The panel source must be in the clk domain.

## Test plan
- Nominal row: 32 shift pulses carrying 0xA5A50F0F (bit c on pulse c), then a lat pulse with pin_row=3 -> one row_valid, row_addr=3, row_data=0xA5A50F0F, err_len=0.
- Short row: 31 pulses of 1, then lat -> row_data=0x7FFFFFFF, err_len=1 and it stays 1 across subsequent good rows until rst.
- On-time and frame: pin_oe low for 8 cycles after latching row 7 -> on_valid with on_time=8 and frame_done=1. With row 2 instead, frame_done=0.
- OE violation: a shift pulse while pin_oe is low -> err_oe=1; the bit is still stored.
- Reset mid-row: 10 pulses, rst for 1 cycle, then 32 pulses of 0xFFFFFFFF and lat -> row_data=0xFFFFFFFF, err_len=0, all outputs 0 during rst.
- Saturation: pin_oe low for 70000 cycles (count_width=16) -> on_time=65535. Run every scenario with and without DISPLAY_CAPTURE_SYNC_EN and check strobe latency of 3 and 1 cycles respectively.
